// File: rtl/coprocessor_scheduler.sv
// Coprocessor scheduler: arbitrates one matrix coprocessor between NUM_REQ requesters.
// Latches the winner's op_code/matrix_size, strobes cop_start and waits for cop_done under
// a watchdog. It then pulses done/err to the owner and holds the one-hot grant until the
// owner drops req.
// All outputs are registered, so each output lags the state that produces it by one cycle.
// For example, cop_start is high during the first BUSY cycle, and done/err are high
// during the first RELEASE cycle.
// Optional build macro: SCHED_FIXED_PRIORITY_EN (lowest index wins, rr_ptr held at 0).
module coprocessor_scheduler #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_op_code,
  input  logic [2*NUM_REQ-1:0] req_matrix_size,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 cop_start,
  output logic [2:0]           cop_op_code,
  output logic [1:0]           cop_matrix_size,
  input  logic                 cop_done
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StBusy, StComplete, StRelease} state_e;

  state_e          state_q;
  logic [PtrW-1:0] rr_ptr_q;
  logic [CNT_W-1:0] timer_q;
  logic            err_flag_q;

  logic            found;
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] rr_next;
  logic [PtrW:0]   cand;
  logic [CNT_W-1:0] timer_inc;

  // Winner search starting at rr_ptr, wrapping modulo NUM_REQ. In the fixed-priority
  // build rr_ptr stays 0, so this reduces to lowest-index-wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(NUM_REQ)) begin
        cand = cand - (PtrW+1)'(NUM_REQ);
      end
      if (!found && req[cand[PtrW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PtrW-1:0];
      end
    end
  end

  // Pointer to the requester after the winner, and the saturating watchdog increment.
  always_comb begin
    rr_next   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      timer_q         <= '0;
      err_flag_q      <= 1'b0;
      grant           <= '0;
      done            <= '0;
      err             <= '0;
      busy            <= 1'b0;
      cop_start       <= 1'b0;
      cop_op_code     <= '0;
      cop_matrix_size <= '0;
    end else begin
      cop_start <= 1'b0;
      done      <= '0;
      err       <= '0;
      case (state_q)
        StIdle: begin
          if (found) begin
            cop_op_code     <= req_op_code[3*win_idx +: 3];
            cop_matrix_size <= req_matrix_size[2*win_idx +: 2];
            grant           <= NUM_REQ'(1) << win_idx;
`ifdef SCHED_FIXED_PRIORITY_EN
            rr_ptr_q        <= '0;
`else
            rr_ptr_q        <= rr_next;
`endif
            busy            <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          cop_start <= 1'b1;
          timer_q   <= '0;
          state_q   <= StBusy;
        end
        StBusy: begin
          timer_q <= timer_inc;
          // timer_q==0 masks a done level left over from the previous operation;
          // a real done beats a simultaneous timeout.
          if (cop_done && (timer_q != '0)) begin
            state_q <= StComplete;
          end else if (timer_inc >= TimeoutLast) begin
            err_flag_q <= 1'b1;
            state_q    <= StComplete;
          end
        end
        StComplete: begin
          done    <= grant;
          err     <= grant & {NUM_REQ{err_flag_q}};
          state_q <= StRelease;
        end
        StRelease: begin
          // Grant is held so the owner can still read results through the external mux.
          if ((req & grant) == '0) begin
            grant      <= '0;
            err_flag_q <= 1'b0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor_scheduler.sv
// Scoreboard bench for coprocessor_scheduler (NUM_REQ=2, TIMEOUT_CYCLES=8).
// The driver pushes expected start/done records; a monitor pops and compares them on
// each cop_start or done pulse. A small coprocessor model answers cop_start.
module tb_coprocessor_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [5:0] req_op_code;
  logic [3:0] req_matrix_size;
  logic [1:0] grant, done, err;
  logic       busy, cop_start, cop_done;
  logic [2:0] cop_op_code;
  logic [1:0] cop_matrix_size;

  coprocessor_scheduler #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .req_op_code     (req_op_code),
    .req_matrix_size (req_matrix_size),
    .grant           (grant),
    .done            (done),
    .err             (err),
    .busy            (busy),
    .cop_start       (cop_start),
    .cop_op_code     (cop_op_code),
    .cop_matrix_size (cop_matrix_size),
    .cop_done        (cop_done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [1:0] g;
    logic [2:0] op;
    logic [1:0] size;
    int         cyc;
  } start_t;

  typedef struct {
    logic [1:0] g;
    logic [1:0] err;
    int         delta;
  } done_t;

  start_t start_q[$];
  done_t  done_q[$];

  // Coprocessor model: mode 0 raises cop_done cop_delay cycles after cop_start and holds it
  // until the next start; mode 1 ties cop_done high; mode 2 ties it low.
  int cop_mode = 0;
  int cop_delay = 3;
  initial begin
    int cnt;
    bit armed;
    cnt = 0;
    armed = 1'b0;
    cop_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cop_mode == 1) cop_done = 1'b1;
      else if (cop_mode == 2) cop_done = 1'b0;
      else if (cop_start) begin
        cop_done = 1'b0;
        cnt = cop_delay - 1;
        armed = 1'b1;
        if (cnt <= 0) begin
          cop_done = 1'b1;
          armed = 1'b0;
        end
      end else if (armed) begin
        cnt--;
        if (cnt <= 0) begin
          cop_done = 1'b1;
          armed = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every start strobe and done pulse against the scoreboard.
  initial begin
    int last_start;
    start_t s;
    done_t d;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (cop_start) begin
        if (start_q.size() == 0) begin
          check("unexpected_start", 32'(cop_start), 32'd0);
        end else begin
          s = start_q.pop_front();
          check("start_grant", 32'(grant), 32'(s.g));
          check("start_op_code", 32'(cop_op_code), 32'(s.op));
          check("start_matrix_size", 32'(cop_matrix_size), 32'(s.size));
          if (s.cyc >= 0) check("start_cycle", 32'(cyc), 32'(s.cyc));
        end
        last_start = cyc;
      end
      if (done != 2'b00) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          d = done_q.pop_front();
          check("done_vec", 32'(done), 32'(d.g));
          check("err_vec", 32'(err), 32'(d.err));
          check("done_latency", 32'(cyc - last_start), 32'(d.delta));
          check("done_eq_grant", 32'(grant), 32'(d.g));
        end
      end
    end
  end

  task automatic push_start(input int idx, input int exp_cyc);
    start_t s;
    s.g    = 2'(1 << idx);
    s.op   = req_op_code[3*idx +: 3];
    s.size = req_matrix_size[2*idx +: 2];
    s.cyc  = exp_cyc;
    start_q.push_back(s);
  endtask

  task automatic push_done(input int idx, input bit is_err, input int delta);
    done_t d;
    d.g     = 2'(1 << idx);
    d.err   = is_err ? 2'(1 << idx) : 2'b00;
    d.delta = delta;
    done_q.push_back(d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (done == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_done_timeout", 32'd1, 32'd0);
    t = cyc;
  endtask

  task automatic wait_start(output int t);
    int n;
    n = 0;
    while (!cop_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_start_timeout", 32'd1, 32'd0);
    t = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 2'b00;
    tick(3);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cop_start", 32'(cop_start), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_cop_fields", 32'({cop_op_code, cop_matrix_size}), 32'd0);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int t;
    int s;
    int exp_g [4];
`ifdef SCHED_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    reset_n = 1'b0;
    req = 2'b00;
    req_op_code = '0;
    req_matrix_size = '0;

    // Reset and single request; cop_done raised when the BUSY timer is 3.
    do_reset();
    req_op_code = 6'b000_010;
    req_matrix_size = 4'b00_11;
    cop_mode = 0;
    cop_delay = 4;
    push_start(0, cyc + 2);
    push_done(0, 1'b0, 5);
    req = 2'b01;
    wait_done(t);
    check("t1_grant_held", 32'(grant), 32'h1);
    req = 2'b00;
    tick(1);
    check("t1_grant_cleared", 32'(grant), 32'h0);
    check("t1_busy_cleared", 32'(busy), 32'h0);

    // Simultaneous contention, four operations, each requester re-raises after release.
    do_reset();
    req_op_code = 6'b101_001;
    req_matrix_size = 4'b10_01;
    cop_delay = 3;
    push_start(exp_g[0], cyc + 2);
    push_done(exp_g[0], 1'b0, 4);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(t);
      if (i < 3) begin
        push_start(exp_g[i+1], t + 3);
        push_done(exp_g[i+1], 1'b0, 4);
        req[exp_g[i]] = 1'b0;
        tick(1);
        req = 2'b11;
      end else begin
        req = 2'b00;
        tick(2);
      end
    end

    // Stale done: cop_done tied high must not complete before timer 1.
    do_reset();
    req_op_code = 6'b000_111;
    req_matrix_size = 4'b00_00;
    cop_mode = 1;
    push_start(0, cyc + 2);
    push_done(0, 1'b0, 3);
    req = 2'b01;
    wait_done(t);
    req = 2'b00;
    tick(2);
    cop_mode = 0;

    // Timeout, then a clean operation from requester 1.
    do_reset();
    req_op_code = 6'b110_011;
    req_matrix_size = 4'b10_01;
    cop_mode = 2;
    push_start(0, cyc + 2);
    push_done(0, 1'b1, 8);
    req = 2'b01;
    wait_done(t);
    req = 2'b00;
    tick(1);
    cop_mode = 0;
    cop_delay = 3;
    push_start(1, cyc + 2);
    push_done(1, 1'b0, 4);
    req = 2'b10;
    wait_done(t);
    req = 2'b00;
    tick(2);

    // Reset during BUSY: abandoned without done; rr_ptr back to requester 0.
    do_reset();
    req_op_code = 6'b010_100;
    req_matrix_size = 4'b01_10;
    cop_mode = 2;
    push_start(0, cyc + 2);
    req = 2'b01;
    wait_start(s);
    tick(2);
    reset_n = 1'b0;
    req = 2'b00;
    tick(1);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cop_start", 32'(cop_start), 32'h0);
    tick(2);
    reset_n = 1'b1;
    cop_mode = 0;
    cop_delay = 3;
    push_start(0, cyc + 2);
    push_done(0, 1'b0, 4);
    req = 2'b11;
    wait_done(t);
    req = 2'b00;
    tick(2);

    // Request dropped during BUSY: done still pulses, IDLE right after RELEASE.
    req_op_code = 6'b001_000;
    req_matrix_size = 4'b11_00;
    push_start(1, cyc + 2);
    push_done(1, 1'b0, 4);
    req = 2'b10;
    wait_start(s);
    tick(1);
    req = 2'b00;
    wait_done(t);
    check("drop_busy_at_done", 32'(busy), 32'h1);
    tick(1);
    check("drop_busy_after", 32'(busy), 32'h0);
    check("drop_grant_after", 32'(grant), 32'h0);

    tick(4);
    check("start_q_empty", 32'(start_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
